// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller: instruction fields,
// ALU operation codes, datapath select encodings and controller states.
package multicycle_ctrl_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] INSTR_OP_RTYPE = 6'h00;
    localparam logic [5:0] INSTR_OP_BEQ   = 6'h04;
    localparam logic [5:0] INSTR_OP_BNE   = 6'h05;
    localparam logic [5:0] INSTR_OP_ADDI  = 6'h08;
    localparam logic [5:0] INSTR_OP_ADDIU = 6'h09;
    localparam logic [5:0] INSTR_OP_SLTI  = 6'h0A;
    localparam logic [5:0] INSTR_OP_SLTIU = 6'h0B;
    localparam logic [5:0] INSTR_OP_ANDI  = 6'h0C;
    localparam logic [5:0] INSTR_OP_ORI   = 6'h0D;
    localparam logic [5:0] INSTR_OP_XORI  = 6'h0E;
    localparam logic [5:0] INSTR_OP_LUI   = 6'h0F;
    localparam logic [5:0] INSTR_OP_LW    = 6'h23;
    localparam logic [5:0] INSTR_OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] INSTR_FUNCT_ADD  = 6'h20;
    localparam logic [5:0] INSTR_FUNCT_ADDU = 6'h21;
    localparam logic [5:0] INSTR_FUNCT_SUB  = 6'h22;
    localparam logic [5:0] INSTR_FUNCT_SUBU = 6'h23;
    localparam logic [5:0] INSTR_FUNCT_AND  = 6'h24;
    localparam logic [5:0] INSTR_FUNCT_OR   = 6'h25;
    localparam logic [5:0] INSTR_FUNCT_XOR  = 6'h26;
    localparam logic [5:0] INSTR_FUNCT_NOR  = 6'h27;
    localparam logic [5:0] INSTR_FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] INSTR_FUNCT_SLTU = 6'h2B;

    // ALU operation codes
    localparam logic [4:0] ALUOp_ADD  = 5'd0;
    localparam logic [4:0] ALUOp_ADDU = 5'd1;
    localparam logic [4:0] ALUOp_SUB  = 5'd2;
    localparam logic [4:0] ALUOp_SUBU = 5'd3;
    localparam logic [4:0] ALUOp_AND  = 5'd4;
    localparam logic [4:0] ALUOp_OR   = 5'd5;
    localparam logic [4:0] ALUOp_XOR  = 5'd6;
    localparam logic [4:0] ALUOp_NOR  = 5'd7;
    localparam logic [4:0] ALUOp_SLT  = 5'd8;
    localparam logic [4:0] ALUOp_SLTU = 5'd9;
    localparam logic [4:0] ALUOp_LUI  = 5'd10;
    localparam logic [4:0] ALUOp_EQL  = 5'd11;
    localparam logic [4:0] ALUOp_BNE  = 5'd12;

    // Datapath select encodings
    localparam logic [1:0] SEL_REGDST_RT = 2'd0;
    localparam logic [1:0] SEL_REGDST_RD = 2'd1;
    localparam logic [1:0] SEL_WB_ALUOUT = 2'd0;
    localparam logic [1:0] SEL_WB_DM     = 2'd1;
    localparam logic       SEL_ALUA_PC   = 1'b0;
    localparam logic       SEL_ALUA_RS   = 1'b1;
    localparam logic [1:0] SEL_ALUB_RT      = 2'd0;
    localparam logic [1:0] SEL_ALUB_FOUR    = 2'd1;
    localparam logic [1:0] SEL_ALUB_IMM     = 2'd2;
    localparam logic [1:0] SEL_ALUB_IMM_SL2 = 2'd3;
    localparam logic       EXT_MODE_UNSIGNED = 1'b0;
    localparam logic       EXT_MODE_SIGNED   = 1'b1;

    // Controller states; IDLE is zero so the reset state reads as all-zero
    localparam logic [3:0] MCS_IDLE   = 4'd0;
    localparam logic [3:0] MCS_FETCH  = 4'd1;
    localparam logic [3:0] MCS_DECODE = 4'd2;
    localparam logic [3:0] MCS_EXEC_R = 4'd3;
    localparam logic [3:0] MCS_EXEC_I = 4'd4;
    localparam logic [3:0] MCS_WB_ALU = 4'd5;
    localparam logic [3:0] MCS_ADDR   = 4'd6;
    localparam logic [3:0] MCS_MEM_RD = 4'd7;
    localparam logic [3:0] MCS_WB_MEM = 4'd8;
    localparam logic [3:0] MCS_MEM_WR = 4'd9;
    localparam logic [3:0] MCS_BRANCH = 4'd10;
    localparam logic [3:0] MCS_TRAP   = 4'd11;

    // Instruction class produced by the decoder
    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_ITYPE   = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_ILLEGAL = 3'd5
    } instr_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: classifies the IR fields and provides
// the ALU operation, immediate extension mode and destination select.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t iclass,
    output logic [4:0]   alu_op,
    output logic         imm_ext,
    output logic [1:0]   reg_dst
);

    // Opcode/funct table lookup; unknown encodings fall out as ILLEGAL
    always_comb begin
        iclass  = CLS_ILLEGAL;
        alu_op  = ALUOp_ADD;
        imm_ext = EXT_MODE_UNSIGNED;
        reg_dst = SEL_REGDST_RT;
        case (opcode)
            INSTR_OP_RTYPE: begin
                iclass  = CLS_RTYPE;
                reg_dst = SEL_REGDST_RD;
                case (funct)
                    INSTR_FUNCT_ADD:  alu_op = ALUOp_ADD;
                    INSTR_FUNCT_ADDU: alu_op = ALUOp_ADDU;
                    INSTR_FUNCT_SUB:  alu_op = ALUOp_SUB;
                    INSTR_FUNCT_SUBU: alu_op = ALUOp_SUBU;
                    INSTR_FUNCT_AND:  alu_op = ALUOp_AND;
                    INSTR_FUNCT_OR:   alu_op = ALUOp_OR;
                    INSTR_FUNCT_XOR:  alu_op = ALUOp_XOR;
                    INSTR_FUNCT_NOR:  alu_op = ALUOp_NOR;
                    INSTR_FUNCT_SLT:  alu_op = ALUOp_SLT;
                    INSTR_FUNCT_SLTU: alu_op = ALUOp_SLTU;
                    default: begin
                        iclass  = CLS_ILLEGAL;
                        reg_dst = SEL_REGDST_RT;
                    end
                endcase
            end
            INSTR_OP_ADDI: begin
                iclass = CLS_ITYPE; alu_op = ALUOp_ADD; imm_ext = EXT_MODE_SIGNED;
            end
            INSTR_OP_ADDIU: begin
                iclass = CLS_ITYPE; alu_op = ALUOp_ADDU; imm_ext = EXT_MODE_SIGNED;
            end
            INSTR_OP_SLTI: begin
                iclass = CLS_ITYPE; alu_op = ALUOp_SLT; imm_ext = EXT_MODE_SIGNED;
            end
            INSTR_OP_SLTIU: begin
                iclass = CLS_ITYPE; alu_op = ALUOp_SLTU; imm_ext = EXT_MODE_SIGNED;
            end
            INSTR_OP_ANDI: begin
                iclass = CLS_ITYPE; alu_op = ALUOp_AND;
            end
            INSTR_OP_ORI: begin
                iclass = CLS_ITYPE; alu_op = ALUOp_OR;
            end
            INSTR_OP_XORI: begin
                iclass = CLS_ITYPE; alu_op = ALUOp_XOR;
            end
            INSTR_OP_LUI: begin
                iclass = CLS_ITYPE; alu_op = ALUOp_LUI;
            end
            INSTR_OP_LW: begin
                iclass = CLS_LOAD; imm_ext = EXT_MODE_SIGNED;
            end
            INSTR_OP_SW: begin
                iclass = CLS_STORE; imm_ext = EXT_MODE_SIGNED;
            end
            INSTR_OP_BEQ: begin
                iclass = CLS_BRANCH; alu_op = ALUOp_EQL;
            end
            INSTR_OP_BNE: begin
                iclass = CLS_BRANCH; alu_op = ALUOp_BNE;
            end
            default: iclass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/writeback
// over a shared req/ready memory port and drives the datapath selects.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               imm_ext,
    output logic               illegal,
    output logic               bus_err,
    output logic [STATE_W-1:0] state
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [3:0]       state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             in_access;
    logic             timeout;
    logic [4:0]       alu_op_c;

    instr_class_t     dec_class;
    logic [4:0]       dec_alu_op;
    logic             dec_imm_ext;
    logic [1:0]       dec_reg_dst;

    ctrl_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .iclass  (dec_class),
        .alu_op  (dec_alu_op),
        .imm_ext (dec_imm_ext),
        .reg_dst (dec_reg_dst)
    );

    assign in_access = (state_reg == MCS_FETCH) || (state_reg == MCS_MEM_RD) ||
                       (state_reg == MCS_MEM_WR);
    // A ready arriving in the timeout cycle still completes the access normally
    assign timeout   = (MEM_TIMEOUT != 0) && in_access && !mem_ready &&
                       (wait_cnt_reg == CNT_W'(MEM_TIMEOUT));

    // State and wait counter registers; reset drops any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= MCS_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Wait counter: zero outside accesses and at the end of each access, so
    // every FETCH/MEM_RD/MEM_WR visit starts counting from zero
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!in_access || mem_ready || timeout) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != {CNT_W{1'b1}}) begin
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
    end

    // Next-state sequencing
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MCS_IDLE:   state_next = MCS_FETCH;
            MCS_FETCH:  state_next = mem_ready ? MCS_DECODE : MCS_FETCH;
            MCS_DECODE: begin
                case (dec_class)
                    CLS_RTYPE:  state_next = MCS_EXEC_R;
                    CLS_ITYPE:  state_next = MCS_EXEC_I;
                    CLS_LOAD,
                    CLS_STORE:  state_next = MCS_ADDR;
                    CLS_BRANCH: state_next = MCS_BRANCH;
                    default:    state_next = MCS_TRAP;
                endcase
            end
            MCS_EXEC_R: state_next = MCS_WB_ALU;
            MCS_EXEC_I: state_next = MCS_WB_ALU;
            MCS_WB_ALU: state_next = MCS_FETCH;
            MCS_ADDR:   state_next = (dec_class == CLS_LOAD) ? MCS_MEM_RD : MCS_MEM_WR;
            MCS_MEM_RD: begin
                if (mem_ready)    state_next = MCS_WB_MEM;
                else if (timeout) state_next = MCS_FETCH;
            end
            MCS_WB_MEM: state_next = MCS_FETCH;
            MCS_MEM_WR: begin
                if (mem_ready || timeout) state_next = MCS_FETCH;
            end
            MCS_BRANCH: state_next = MCS_FETCH;
            MCS_TRAP:   state_next = MCS_FETCH;
            default:    state_next = MCS_IDLE;
        endcase
    end

    // Output decode from the current state and the IR fields
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = SEL_REGDST_RT;
        mem_to_reg    = SEL_WB_ALUOUT;
        alu_src_a     = SEL_ALUA_PC;
        alu_src_b     = SEL_ALUB_RT;
        alu_op_c      = ALUOp_ADD;
        imm_ext       = EXT_MODE_UNSIGNED;
        illegal       = 1'b0;
        bus_err       = timeout;
        case (state_reg)
            MCS_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SEL_ALUB_FOUR;
                alu_op_c  = ALUOp_ADDU;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            MCS_DECODE: begin
                // Speculative branch target: PC + (sign-extended imm << 2)
                alu_src_b = SEL_ALUB_IMM_SL2;
                alu_op_c  = ALUOp_ADDU;
                imm_ext   = EXT_MODE_SIGNED;
            end
            MCS_EXEC_R: begin
                alu_src_a = SEL_ALUA_RS;
                alu_src_b = SEL_ALUB_RT;
                alu_op_c  = dec_alu_op;
            end
            MCS_EXEC_I: begin
                alu_src_a = SEL_ALUA_RS;
                alu_src_b = SEL_ALUB_IMM;
                alu_op_c  = dec_alu_op;
                imm_ext   = dec_imm_ext;
            end
            MCS_WB_ALU: begin
                reg_write  = 1'b1;
                mem_to_reg = SEL_WB_ALUOUT;
                reg_dst    = dec_reg_dst;
            end
            MCS_ADDR: begin
                alu_src_a = SEL_ALUA_RS;
                alu_src_b = SEL_ALUB_IMM;
                alu_op_c  = ALUOp_ADD;
                imm_ext   = EXT_MODE_SIGNED;
            end
            MCS_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            MCS_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = SEL_WB_DM;
                reg_dst    = SEL_REGDST_RT;
            end
            MCS_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
            end
            MCS_BRANCH: begin
                alu_src_a     = SEL_ALUA_RS;
                alu_src_b     = SEL_ALUB_RT;
                pc_write_cond = 1'b1;
                alu_op_c      = dec_alu_op;
            end
            MCS_TRAP: illegal = 1'b1;
            default: ;
        endcase
    end

    assign alu_op = ALUOP_W'(alu_op_c);
    assign state  = STATE_W'(state_reg);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction reference model
// builds the expected cycle-by-cycle output trace and memory-ready schedule.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b;
    logic       alu_src_a, imm_ext, illegal, bus_err;
    logic [4:0] alu_op;
    logic [3:0] state;

    multicycle_ctrl #(.ALUOP_W(5), .MEM_TIMEOUT(TO), .STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_ext(imm_ext), .illegal(illegal),
        .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [4:0] alu_op;
        logic       imm_ext, illegal, bus_err;
        logic [3:0] state;
    } vec_t;

    vec_t obs;
    assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, reg_write,
                  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, imm_ext, illegal,
                  bus_err, state};

    int         compared = 0;
    int         mismatched = 0;
    vec_t       exp_q[$];
    bit         rdy_q[$];
    logic [5:0] cur_op, cur_fn;

    task automatic check(string tag, vec_t e);
        compared++;
        assert (obs === e) else begin
            mismatched++;
            $error("FAIL %s: observed %h required %h", tag, obs, e);
        end
    endtask

    function automatic vec_t at(logic [3:0] st);
        vec_t e = '0;
        e.state = st;
        return e;
    endfunction

    task automatic push(vec_t e, bit r);
        exp_q.push_back(e);
        rdy_q.push_back(r);
    endtask

    // One memory access: w not-ready cycles before ready; more than TO waits
    // means TO waits followed by a bus-error cycle and the access is dropped.
    task automatic add_access(logic [3:0] st, int w, output bit ok);
        vec_t e;
        int   n;
        e = at(st);
        n = (w > TO) ? TO : w;
        e.mem_req = 1'b1;
        if (st == MCS_FETCH) begin
            e.alu_src_b = 2'd1;
            e.alu_op    = ALUOp_ADDU;
        end else begin
            e.i_or_d = 1'b1;
            e.mem_we = (st == MCS_MEM_WR);
        end
        for (int i = 0; i < n; i++) push(e, 1'b0);
        if (w <= TO) begin
            if (st == MCS_FETCH) begin
                e.ir_write = 1'b1;
                e.pc_write = 1'b1;
            end
            push(e, 1'b1);
            ok = 1'b1;
        end else begin
            e.bus_err = 1'b1;
            push(e, 1'b0);
            ok = 1'b0;
        end
    endtask

    function automatic bit r_legal(logic [5:0] f);
        return (f >= 6'h20 && f <= 6'h27) || f == 6'h2A || f == 6'h2B;
    endfunction

    function automatic logic [4:0] r_aluop(logic [5:0] f);
        case (f)
            6'h20: return ALUOp_ADD;   6'h21: return ALUOp_ADDU;
            6'h22: return ALUOp_SUB;   6'h23: return ALUOp_SUBU;
            6'h24: return ALUOp_AND;   6'h25: return ALUOp_OR;
            6'h26: return ALUOp_XOR;   6'h27: return ALUOp_NOR;
            6'h2A: return ALUOp_SLT;   default: return ALUOp_SLTU;
        endcase
    endfunction

    function automatic logic [4:0] i_aluop(logic [5:0] op);
        case (op)
            6'h08: return ALUOp_ADD;   6'h09: return ALUOp_ADDU;
            6'h0A: return ALUOp_SLT;   6'h0B: return ALUOp_SLTU;
            6'h0C: return ALUOp_AND;   6'h0D: return ALUOp_OR;
            6'h0E: return ALUOp_XOR;   default: return ALUOp_LUI;
        endcase
    endfunction

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected trace of one instruction, from its FETCH up to the next FETCH
    task automatic build_instr(logic [5:0] op, logic [5:0] fn, int wf, int wm);
        vec_t e;
        bit   ok;
        exp_q.delete();
        rdy_q.delete();
        cur_op = op;
        cur_fn = fn;
        add_access(MCS_FETCH, wf, ok);
        if (!ok) add_access(MCS_FETCH, wf % (TO + 1), ok);
        e = at(MCS_DECODE);
        e.alu_src_b = 2'd3; e.imm_ext = 1'b1; e.alu_op = ALUOp_ADDU;
        push(e, rnd());
        if (op == 6'h00 && r_legal(fn)) begin
            e = at(MCS_EXEC_R);
            e.alu_src_a = 1'b1; e.alu_src_b = 2'd0; e.alu_op = r_aluop(fn);
            push(e, rnd());
            e = at(MCS_WB_ALU);
            e.reg_write = 1'b1; e.mem_to_reg = SEL_WB_ALUOUT; e.reg_dst = SEL_REGDST_RD;
            push(e, rnd());
        end else if (op >= 6'h08 && op <= 6'h0F) begin
            e = at(MCS_EXEC_I);
            e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = i_aluop(op);
            e.imm_ext = (op <= 6'h0B) ? EXT_MODE_SIGNED : EXT_MODE_UNSIGNED;
            push(e, rnd());
            e = at(MCS_WB_ALU);
            e.reg_write = 1'b1; e.mem_to_reg = SEL_WB_ALUOUT; e.reg_dst = SEL_REGDST_RT;
            push(e, rnd());
        end else if (op == 6'h23 || op == 6'h2B) begin
            e = at(MCS_ADDR);
            e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.imm_ext = EXT_MODE_SIGNED;
            e.alu_op = ALUOp_ADD;
            push(e, rnd());
            add_access((op == 6'h23) ? MCS_MEM_RD : MCS_MEM_WR, wm, ok);
            if (op == 6'h23 && ok) begin
                e = at(MCS_WB_MEM);
                e.reg_write = 1'b1; e.mem_to_reg = SEL_WB_DM; e.reg_dst = SEL_REGDST_RT;
                push(e, rnd());
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            e = at(MCS_BRANCH);
            e.alu_src_a = 1'b1; e.alu_src_b = 2'd0; e.pc_write_cond = 1'b1;
            e.alu_op = (op == 6'h04) ? ALUOp_EQL : ALUOp_BNE;
            push(e, rnd());
        end else begin
            e = at(MCS_TRAP);
            e.illegal = 1'b1;
            push(e, rnd());
        end
    endtask

    task automatic play(string name, int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            opcode    = cur_op;
            funct     = cur_fn;
            mem_ready = rdy_q[i];
            @(negedge clk);
            check($sformatf("%s cyc%0d", name, i), exp_q[i]);
        end
        $display("txn %-8s op=%02h fn=%02h cycles=%0d", name, cur_op, cur_fn, n);
    endtask

    task automatic run_instr(string name, logic [5:0] op, logic [5:0] fn, int wf, int wm);
        build_instr(op, fn, wf, wm);
        play(name, exp_q.size());
    endtask

    // Caller holds rst_n low; outputs must be zero, then one IDLE cycle after release
    task automatic reset_release(string tag);
        mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check({tag, " in-reset"}, '0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check({tag, " idle"}, '0);
        $display("txn reset %s", tag);
    endtask

    logic [5:0] op_tab[14] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B,
                               6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
    logic [5:0] fn_tab[10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                               6'h27, 6'h2A, 6'h2B};

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op, fn;
        reset_release("por");

        run_instr("ADD",     6'h00, 6'h20, 0, 0);
        run_instr("LW",      6'h23, 6'h00, 0, 3);
        run_instr("BNE",     6'h05, 6'h00, 0, 0);
        run_instr("OP3F",    6'h3F, 6'h00, 0, 0);
        run_instr("FN3F",    6'h00, 6'h3F, 0, 0);
        run_instr("FETCHTO", 6'h00, 6'h21, 9, 0);
        run_instr("LW-TO",   6'h23, 6'h00, 1, 7);
        run_instr("LW-EDGE", 6'h23, 6'h00, 4, 4);
        run_instr("SW-TO",   6'h2B, 6'h00, 0, 5);
        run_instr("SW",      6'h2B, 6'h00, 2, 1);
        run_instr("ORI",     6'h0D, 6'h00, 0, 0);
        run_instr("SLTI",    6'h0A, 6'h00, 1, 0);
        run_instr("BEQ",     6'h04, 6'h00, 0, 0);

        // Asynchronous reset in the first MEM_WR wait cycle
        build_instr(6'h2B, 6'h00, 0, 6);
        play("SW-RST", 4);
        #2 rst_n = 1'b0;
        mem_ready = 1'b1;
        #1 check("async-reset", '0);
        reset_release("mid-memwr");
        run_instr("SW-AFTER", 6'h2B, 6'h00, 0, 0);

        for (int k = 0; k < 60; k++) begin
            op = ($urandom_range(0, 3) != 0) ? op_tab[$urandom_range(0, 13)] : 6'($urandom);
            fn = ($urandom_range(0, 3) != 0) ? fn_tab[$urandom_range(0, 9)] : 6'($urandom);
            run_instr($sformatf("rnd%0d", k), op, fn,
                      int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
